spi_slave_param: RTL
====================

Name: spi_slave_param

Overview:
Parametrised successor to the fixed 10-bit SPI slave that fronts the single-port RAM. It deserialises command/payload frames from MOSI and presents them as {cmd[1:0], data} words with a one-cycle rx_valid strobe. For read-data commands it fetches a DATA_W-bit word over a tx_valid handshake and serialises it on MISO. New relative to the previous generation: configurable data width and bit order, back-to-back frames under one SS_n, a bounded wait for tx_valid, and frame/sequence error reporting.

Parameters:
DATA_W, 8, payload width; rx word is DATA_W+2 bits, tx word is DATA_W bits.
MSB_FIRST, 1, 1 = first serial bit maps to MSB of the word (rx and tx); 0 = LSB first.
TX_TIMEOUT, 16, maximum cycles in WAIT_TX before giving up (>=1).

Ports:
clk  in  1  system clock; MOSI sampled and MISO updated on rising edge (SPI bit rate = clk).
rst  in  1  synchronous reset, active-high.
SS_n  in  1  slave select, active-low.
MOSI  in  1  serial data in.
MISO  out  1  serial data out.
rx_data  out  DATA_W+2  received word, [DATA_W+1:DATA_W] = cmd (00 wr addr, 01 wr data, 10 rd addr, 11 rd data).
rx_valid  out  1  one-cycle strobe, rx_data valid.
tx_data  in  DATA_W  read data from RAM.
tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
busy  out  1  high in any state other than IDLE.
frame_err  out  1  one-cycle pulse: SS_n rose during RX_SHIFT, WAIT_TX or TX_SHIFT.
seq_err  out  1  one-cycle pulse: cmd 11 received with no preceding completed cmd 10.
tx_timeout  out  1  sticky; set on WAIT_TX expiry, cleared by rst or next successful tx_valid capture.

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; MISO=0, rx_valid=0, rx_data=0, busy=0, frame_err=0, seq_err=0, tx_timeout=0; bit counter, addr_ok flag and tx shift register cleared. rst takes priority over all other activity, including mid-frame.
- States: IDLE, CHK_CMD, RX_SHIFT, WAIT_TX, TX_SHIFT.
- IDLE: SS_n=0 -> CHK_CMD. MISO held 0.
- CHK_CMD: one cycle; the MOSI value is a direction bit (0 write, 1 read), recorded only, not stored in rx_data. SS_n=1 -> IDLE (no error). Else -> RX_SHIFT, counter=0.
- RX_SHIFT: exactly DATA_W+2 cycles, one MOSI bit per cycle into the shift register, placed per MSB_FIRST. On the edge sampling the final bit: rx_data loaded with the full word, rx_valid=1 for the next cycle only.
  After the final bit: cmd 10 sets addr_ok. Cmd 11 with addr_ok=1 -> WAIT_TX and clears addr_ok. Cmd 11 with addr_ok=0 -> seq_err pulse, no tx phase. All other cases -> CHK_CMD if SS_n=0, else IDLE.
- WAIT_TX: capture tx_data into the tx shift register on the first cycle tx_valid=1, clear tx_timeout, -> TX_SHIFT. If TX_TIMEOUT cycles elapse without tx_valid: tx shift register=0, tx_timeout=1, -> TX_SHIFT (zeros sent).
- TX_SHIFT: DATA_W cycles; each cycle MISO drives the next bit per MSB_FIRST. The first bit appears the cycle after entry. Then -> CHK_CMD if SS_n=0, else IDLE. MISO returns to 0 on exit.
- SS_n=1 in RX_SHIFT/WAIT_TX/TX_SHIFT: frame_err pulses; -> IDLE next cycle; partial word discarded; rx_valid not asserted; addr_ok unchanged; MISO=0.
- rx_data holds its value between frames; rx_valid never asserts for more than one cycle.
- Back-to-back: a frame ending with SS_n still low re-enters CHK_CMD with no gap cycle.
- tx_valid outside WAIT_TX is ignored.
- addr_ok is cleared only by rst or by consumption in a cmd 11; it survives SS_n deassertion.

Test Plan:
- Write addr, DATA_W=8, MSB_FIRST=1: SS_n low, MOSI 0 then 0,0,1,0,1,0,0,1,0,1 -> rx_valid one cycle after the 10th bit with rx_data=10'h0A5; busy high throughout; SS_n high -> IDLE.
- Back-to-back write addr then write data 10'h1_3C under one SS_n -> two rx_valid pulses exactly 11 cycles apart, values 10'h0A5 then 10'h13C.
- Read addr 10'h2_10 then read data frame; tx_valid asserted 3 cycles into WAIT_TX with tx_data=8'hC6 -> MISO bits 1,1,0,0,0,1,1,0 on consecutive cycles. Repeat with MSB_FIRST=0 -> 0,1,1,0,0,0,1,1.
- Read data (cmd 11) with no prior cmd 10 -> rx_valid pulse, seq_err pulse, MISO stays 0, next state CHK_CMD.
- Read data with tx_valid held low and TX_TIMEOUT=16 -> after 16 WAIT_TX cycles tx_timeout=1 and 8 zero bits on MISO; next successful read clears tx_timeout.
- SS_n raised after 5 bits of RX_SHIFT -> frame_err pulse, no rx_valid, IDLE next cycle. rst asserted mid-TX_SHIFT -> MISO=0 and all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave for the single-port RAM front end.
// A frame is one direction bit followed by DATA_W+2 bits, {cmd[1:0], data}.
// When a read-data command follows a completed read-address command, the
// slave waits a bounded time for tx_valid and then shifts DATA_W bits out on
// MISO. Several frames may follow each other under one SS_n assertion.
// DATA_W must be at least 2.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              seq_err,
  output logic              tx_timeout
);

  localparam int RX_W   = DATA_W + 2;
  localparam int BCNT_W = $clog2(RX_W + 1);
  localparam int WCNT_W = $clog2(TX_TIMEOUT + 1);

  localparam logic [BCNT_W-1:0] RX_LAST   = BCNT_W'(RX_W - 1);
  localparam logic [BCNT_W-1:0] TX_LAST   = BCNT_W'(DATA_W - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK_CMD  = 3'd1,
    RX_SHIFT = 3'd2,
    WAIT_TX  = 3'd3,
    TX_SHIFT = 3'd4
  } state_t;

  state_t              state_reg;
  logic [BCNT_W-1:0]   bit_cnt_reg;
  logic [WCNT_W-1:0]   wait_cnt_reg;
  // Holds only the bits already received; the bit on MOSI this cycle
  // completes the word, so one fewer flop than the word width is needed.
  logic [RX_W-2:0]     rx_sr_reg;
  logic [DATA_W-1:0]   tx_sr_reg;
  logic                addr_ok_reg;

  logic [RX_W-1:0]     rx_word_next;
  logic [RX_W-2:0]     rx_sr_next;
  logic [DATA_W-1:0]   tx_sr_shifted;
  logic                tx_bit;
  logic [1:0]          cmd_next;

  // Bit-order dependent placement of incoming and outgoing bits.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign rx_word_next  = {rx_sr_reg, MOSI};
      assign rx_sr_next    = rx_word_next[RX_W-2:0];
      assign tx_bit        = tx_sr_reg[DATA_W-1];
      assign tx_sr_shifted = {tx_sr_reg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign rx_word_next  = {MOSI, rx_sr_reg};
      assign rx_sr_next    = rx_word_next[RX_W-1:1];
      assign tx_bit        = tx_sr_reg[0];
      assign tx_sr_shifted = {1'b0, tx_sr_reg[DATA_W-1:1]};
    end
  endgenerate

  assign cmd_next = rx_word_next[RX_W-1:RX_W-2];

  // busy is a direct decode of the state register.
  assign busy = (state_reg != IDLE);

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      rx_sr_reg    <= '0;
      tx_sr_reg    <= '0;
      addr_ok_reg  <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      seq_err      <= 1'b0;
      tx_timeout   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          MISO <= 1'b0;
          if (!SS_n) state_reg <= CHK_CMD;
        end
        // The direction bit on MOSI is informational only; the cmd field
        // of the frame decides what happens, so it is not stored.
        CHK_CMD: begin
          MISO        <= 1'b0;
          bit_cnt_reg <= '0;
          state_reg   <= SS_n ? IDLE : RX_SHIFT;
        end
        RX_SHIFT: begin
          MISO <= 1'b0;
          if (SS_n) begin
            frame_err <= 1'b1;
            state_reg <= IDLE;
          end else begin
            rx_sr_reg   <= rx_sr_next;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == RX_LAST) begin
              rx_data   <= rx_word_next;
              rx_valid  <= 1'b1;
              state_reg <= CHK_CMD;
              if (cmd_next == 2'b10) begin
                addr_ok_reg <= 1'b1;
              end else if (cmd_next == 2'b11) begin
                if (addr_ok_reg) begin
                  addr_ok_reg  <= 1'b0;
                  wait_cnt_reg <= '0;
                  state_reg    <= WAIT_TX;
                end else begin
                  seq_err <= 1'b1;
                end
              end
            end
          end
        end
        // tx_valid wins over expiry on the last allowed cycle.
        WAIT_TX: begin
          MISO <= 1'b0;
          if (SS_n) begin
            frame_err <= 1'b1;
            state_reg <= IDLE;
          end else if (tx_valid) begin
            tx_sr_reg   <= tx_data;
            tx_timeout  <= 1'b0;
            bit_cnt_reg <= '0;
            state_reg   <= TX_SHIFT;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            tx_sr_reg   <= '0;
            tx_timeout  <= 1'b1;
            bit_cnt_reg <= '0;
            state_reg   <= TX_SHIFT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        // MISO is registered, so each bit shows up one cycle after the
        // edge that selects it; the last bit is visible in the following
        // CHK_CMD cycle and MISO drops back to 0 after that.
        TX_SHIFT: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            MISO      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            MISO        <= tx_bit;
            tx_sr_reg   <= tx_sr_shifted;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == TX_LAST) state_reg <= CHK_CMD;
          end
        end
        default: begin
          MISO      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
